matmul_host_sequencer: RTL
==========================

# matmul_host_sequencer

Host-side sequencer that drives the 3x3 matrix multiplier from the initiator end. It accepts A and B as a byte stream over a valid/ready input, presents them packed to the multiplier, and raises and holds Enable until done. It then captures C and returns it as a byte stream over a valid/ready output. It sits between a serial front end (UART/FIFO) and `matrix_multiplication`, replacing bench-driven stimulus on hardware.

## Interface
Parameters:
- `ELEM_W`, 8, element width in bits
- `N_ELEM`, 9, elements per matrix (3x3, row-major)
- `TIMEOUT_CYCLES`, 1024, WAIT-state limit (used only with `MM_SEQ_TIMEOUT_EN`)

Ports:
- `Clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; all state cleared immediately
- `in_data` in 8: input byte
- `in_valid` in 1: input byte valid
- `in_ready` out 1: sequencer can accept a byte
- `out_data` out 8: output byte (C element)
- `out_valid` out 1: output byte valid
- `out_ready` in 1: sink accepts the byte
- `mm_A` out 72: packed A to the multiplier
- `mm_B` out 72: packed B to the multiplier
- `mm_Enable` out 1: multiplier enable
- `mm_C` in 72: packed C from the multiplier
- `mm_done` in 1: multiplier complete
- `busy` out 1: high in every state except LOAD_A with element count 0
- `timeout_err` out 1: sticky error flag, cleared on the next accepted input byte

## Operation
- Packing: element k = i*3+j occupies bits [k*8 +: 8] of `mm_A`, `mm_B` and `mm_C`. The first stream byte is element 0.
- States: LOAD_A, LOAD_B, START, WAIT, DRAIN.
- LOAD_A: `in_ready`=1. Each handshake (`in_valid`&&`in_ready`) writes `in_data` to `mm_A` element cnt, then cnt++. After element 8: cnt←0, go to LOAD_B.
- LOAD_B: same as LOAD_A, into `mm_B`. After element 8: go to START.
- START: `in_ready`=0. Stays until `mm_done`=0 (rejects a stale done), then sets `mm_Enable`=1 and goes to WAIT.
- WAIT: `mm_Enable` held 1. On the first cycle `mm_done`=1: register `mm_C` into the capture register, clear `mm_Enable`, cnt←0, go to DRAIN.
- DRAIN: `out_valid`=1, `out_data`=capture element cnt. On handshake cnt++. After element 8 is accepted: `out_valid`←0, cnt←0, go to LOAD_A.
- `out_data`/`out_valid` stay stable while `out_ready`=0.
- `mm_A`/`mm_B` keep their values after a run. A new load overwrites them element by element.
- No arithmetic is performed. Bytes pass through unmodified.

## Timing
- Reset values:
  - state=LOAD_A, cnt=0
  - `in_ready`=1, `out_valid`=0, `out_data`=0
  - `mm_A`=0, `mm_B`=0, `mm_Enable`=0
  - `busy`=0, `timeout_err`=0
- Load: 18 handshakes minimum, 1 byte/cycle at full rate. Gaps in `in_valid` stall without loss.
- The cycle after the 18th handshake, state=START. `mm_Enable` rises on the next edge if `mm_done`=0.
- `mm_Enable` falls on the edge that samples `mm_done`=1. `out_valid` rises on that same edge.
- Output: 9 handshakes minimum, 1 byte/cycle. Back-to-back runs need no idle cycle: `in_ready`=1 the cycle after the last output handshake.
- Reset mid-operation (any state) aborts the run. Outputs return to reset values asynchronously, and the partial capture is discarded.

## Configuration
- `MM_SEQ_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs while in WAIT.
  - After `TIMEOUT_CYCLES` cycles in WAIT without `mm_done`: `mm_Enable`←0, `timeout_err`←1, cnt←0, go to LOAD_A. No output is produced.
- `MM_SEQ_TIMEOUT_EN` undefined:
  - No counter is built. WAIT is unbounded.
  - `timeout_err` is tied to 0.

## Test plan
- Full-rate run:
  - Stimulus: stream A=1..9 and B=9..8..1 with `in_valid` held high. Bench model multiplier asserts done 5 cycles after Enable.
  - Required: output bytes 30,24,18,84,69,54,138,114,90 in order. `mm_Enable` high for exactly 5 cycles.
- Backpressure:
  - Stimulus: same data, with `out_ready` toggled 1,0,0,1,…
  - Required: identical byte sequence. `out_data` stable across every stall. No byte dropped or duplicated.
- Input gaps:
  - Stimulus: `in_valid` asserted every 3rd cycle.
  - Required: `mm_A`=packed 1..9 with element 0 at [7:0]. START is reached only after the 18th accepted byte.
- Stale done:
  - Stimulus: hold `mm_done`=1 on entry to START, release after 4 cycles.
  - Required: `mm_Enable` stays 0 until the cycle after `mm_done` falls.
- Reset mid-WAIT:
  - Stimulus: assert `reset` 2 cycles into WAIT.
  - Required: `mm_Enable`=0 and `out_valid`=0 immediately, state=LOAD_A, `mm_A`=`mm_B`=0.
  - Follow-up: a subsequent full run produces correct output.
- Timeout (with `MM_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):
  - Stimulus: model never asserts done.
  - Required: `mm_Enable` falls after 16 WAIT cycles, `timeout_err`=1, `in_ready`=1, no output bytes.
  - Follow-up: `timeout_err` clears on the next accepted input byte.

Source files
------------

// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer for the 3x3 matrix multiplier: byte stream in (A then B), run, byte stream out (C).
// Optional WAIT-state watchdog is built only when MM_SEQ_TIMEOUT_EN is defined.
module matmul_host_sequencer #(
    parameter int ELEM_W         = 8,
    parameter int N_ELEM         = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     Clock,
    input  logic                     reset,
    input  logic [ELEM_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [ELEM_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ELEM_W*N_ELEM-1:0] mm_A,
    output logic [ELEM_W*N_ELEM-1:0] mm_B,
    output logic                     mm_Enable,
    input  logic [ELEM_W*N_ELEM-1:0] mm_C,
    input  logic                     mm_done,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int              CNT_W    = $clog2(N_ELEM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ELEM - 1);

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ELEM_W-1:0] r_a   [N_ELEM];
    logic [ELEM_W-1:0] r_b   [N_ELEM];
    logic [ELEM_W-1:0] r_cap [N_ELEM];
    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_cnt_last;
    logic              w_timeout;

    assign w_in_hs    = in_valid && in_ready;
    assign w_out_hs   = out_valid && out_ready;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    for (genvar k = 0; k < N_ELEM; k++) begin : g_pack
        assign mm_A[k*ELEM_W +: ELEM_W] = r_a[k];
        assign mm_B[k*ELEM_W +: ELEM_W] = r_b[k];
    end

`ifdef MM_SEQ_TIMEOUT_EN
    localparam int               WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout_err;

    assign w_timeout   = (r_state == S_WAIT) && (r_wait_cnt == WAIT_LAST);
    assign timeout_err = r_timeout_err;

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 1'b1 : '0;
            // A completing multiplier wins over an expiring watchdog on the same edge
            if (w_timeout && !mm_done)
                r_timeout_err <= 1'b1;
            else if (w_in_hs)
                r_timeout_err <= 1'b0;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge Clock or posedge reset) begin
        if (reset)
            r_state <= S_LOAD_A;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD_A: if (w_in_hs && w_cnt_last) w_next = S_LOAD_B;
            S_LOAD_B: if (w_in_hs && w_cnt_last) w_next = S_START;
            // A done left high from a previous run must not be taken as completion
            S_START:  if (!mm_done) w_next = S_WAIT;
            S_WAIT: begin
                if (mm_done)
                    w_next = S_DRAIN;
                else if (w_timeout)
                    w_next = S_LOAD_A;
            end
            S_DRAIN:  if (w_out_hs && w_cnt_last) w_next = S_LOAD_A;
            default:  w_next = S_LOAD_A;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        mm_Enable = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_LOAD_A: begin
                in_ready = 1'b1;
                busy     = (r_cnt != '0);
            end
            S_LOAD_B: in_ready = 1'b1;
            S_WAIT:   mm_Enable = 1'b1;
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = r_cap[r_cnt];
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            for (int k = 0; k < N_ELEM; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_cap[k] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD_A: begin
                    if (w_in_hs) begin
                        r_a[r_cnt] <= in_data;
                        r_cnt      <= w_cnt_last ? '0 : r_cnt + 1'b1;
                    end
                end
                S_LOAD_B: begin
                    if (w_in_hs) begin
                        r_b[r_cnt] <= in_data;
                        r_cnt      <= w_cnt_last ? '0 : r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mm_done) begin
                        for (int k = 0; k < N_ELEM; k++)
                            r_cap[k] <= mm_C[k*ELEM_W +: ELEM_W];
                    end
                    if (mm_done || w_timeout)
                        r_cnt <= '0;
                end
                S_DRAIN: begin
                    if (w_out_hs)
                        r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
